uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin controller that shares the single UART transmitter among NUM_REQ byte producers (e.g. CPU port, debug port, loopback).
- Accepts bytes over per-requester valid/ready handshakes.
- Sequences the transmitter's tx_en/tx_data/tx_done protocol.
- Supports multi-byte packets that hold the grant until a last-flagged byte.
- Enforces a programmable idle gap between frames.
- Sits between the requesters and the transmitter inside the uart top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match transmitter data width
GAP_W, 16, width of inter-frame gap counter

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  NUM_REQ  per-requester byte valid
req_data_i  in  NUM_REQ*DATA_W  packed bytes; requester k at [k*DATA_W +: DATA_W]
req_last_i  in  NUM_REQ  byte is last of packet; releases the grant
req_ready_o  out  NUM_REQ  per-requester accept, at most one bit high
gap_cycles_i  in  GAP_W  extra idle cycles after each frame
tx_en_o  out  1  transmitter enable; high for the whole frame
tx_data_o  out  DATA_W  byte to transmitter, stable while tx_en_o high
tx_done_i  in  1  one-cycle pulse from transmitter at end of stop bit
grant_o  out  NUM_REQ  one-hot current owner, 0 when none
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low: rst_ni low forces every output to 0 immediately. State = IDLE, round-robin pointer = NUM_REQ-1, lock cleared, gap counter 0.
  - Reset mid-frame drops tx_en_o at once, aborting the frame.
- States: IDLE, LOCKED, TX, GAP.
- IDLE:
  - If any req_valid_i is set, the winner is chosen combinationally. Search starts at pointer+1 and wraps modulo NUM_REQ.
  - req_ready_o[winner] = 1 in the same cycle; transfer occurs on valid&&ready.
  - Next cycle: tx_data_o = captured byte, tx_en_o = 1, grant_o = onehot(winner), state TX.
  - Latency: valid at cycle t in IDLE -> tx_en_o high at t+1.
- LOCKED:
  - Only the owner is served. req_ready_o[owner] = req_valid_i[owner] path as in IDLE. Other requesters get ready = 0 regardless of valid.
  - No timeout: waits indefinitely for the owner.
- TX:
  - tx_en_o and tx_data_o are held constant. All req_ready_o = 0.
  - On tx_done_i: tx_en_o <= 0.
  - Gap counter <= gap_cycles_i, sampled only at this cycle.
  - If the captured last flag is 1: pointer <= owner, lock cleared. Otherwise lock is set.
  - Next state is GAP.
- GAP:
  - tx_en_o = 0; counter decrements each cycle.
  - When the counter is 0: go to LOCKED if the lock is set, else go to IDLE and clear grant_o.
  - tx_en_o is therefore low for exactly 1 + gap_cycles_i cycles between consecutive frames, always at least 1.
- tx_done_i outside TX is ignored.
- Requester data and last are sampled only at the handshake cycle; later changes have no effect.
- Simultaneous valids are resolved purely by round-robin. A requester just served has the lowest priority next arbitration.
- grant_o holds the owner from handshake+1 through the end of GAP. While LOCKED it stays at the owner.
- busy_o = (state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - enum arb_state_e {IDLE, LOCKED, TX, GAP}
  - localparam UART_DATA_W = 8
  - default GAP width constant
- One sub-module rr_arbiter(NUM_REQ):
  - inputs: req vector, pointer
  - output: one-hot grant
  - purely combinational, rotate-priority-encode-rotate
- This block holds the FSM, capture registers, lock flag, pointer and gap counter.

Test Plan:
- Single byte: req_valid_i=4'b0001, data 0x55, last=1, gap=0.
  - Expect ready[0] pulse, tx_en_o high next cycle with tx_data_o=0x55.
  - Expect tx_en_o low the cycle after tx_done_i, then grant_o=0 and busy_o=0.
- Fairness: all four requesters continuously valid with last=1.
  - Expect service order 0,1,2,3,0,1 and no requester granted twice before the others.
- Packet lock: requester 2 sends 0xA1 (last=0) then 0xA2 (last=1) while requester 0 stays valid.
  - Expect 0xA1, 0xA2 sent back-to-back, then requester 0 is served.
  - Expect req_ready_o[0] stays 0 throughout.
- Gap: gap_cycles_i=5 with two queued single-byte frames.
  - Expect tx_en_o low exactly 6 cycles between tx_done_i and the next tx_en_o rise.
  - Change gap_cycles_i mid-GAP; expect no effect on the current gap.
- Reset mid-frame: assert rst_ni low during TX, asynchronous to clk_i.
  - Expect tx_en_o, grant_o, busy_o and req_ready_o to be 0 immediately.
  - After release, the first arbitration starts from requester 0.
- Spurious done: pulse tx_done_i in IDLE and in GAP.
  - Expect no state change and no ready or tx_en activity.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding and default widths.
package uart_pkg;

    localparam int unsigned UART_DATA_W   = 8;
    localparam int unsigned DEFAULT_GAP_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        TX     = 2'd2,
        GAP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Per-requester byte handshake bundle between producers (master) and the arbiter (slave).
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = uart_pkg::UART_DATA_W
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr_i and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    logic [PtrW-1:0]    start;
    logic [PtrW-1:0]    idx;
    logic [NUM_REQ-1:0] rot_req;
    logic [NUM_REQ-1:0] rot_gnt;

    always_comb begin
        start   = (ptr_i == PtrW'(NUM_REQ - 1)) ? '0 : ptr_i + PtrW'(1);
        rot_req = '0;
        gnt_o   = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx        = PtrW'((i + int'(start)) % NUM_REQ);
            rot_req[i] = req_i[idx];
        end
        // Lowest set bit of the rotated vector is the winner.
        rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
        for (int i = 0; i < NUM_REQ; i++) begin
            idx        = PtrW'((i + int'(start)) % NUM_REQ);
            gnt_o[idx] = rot_gnt[i];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin,
// packet locking and a programmable inter-frame idle gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = UART_DATA_W,
    parameter int unsigned GAP_W   = DEFAULT_GAP_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    uart_tx_arbiter_if.slave    req_bus,
    input  logic [GAP_W-1:0]    gap_cycles_i,
    output logic                tx_en_o,
    output logic [DATA_W-1:0]   tx_data_o,
    input  logic                tx_done_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic                busy_o
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    owner_q, owner_d;
    logic               lock_q, lock_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               last_q, last_d;
    logic               tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] ready;
    logic               arb_open, own_open;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic [PtrW-1:0]    sel_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (req_bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        // The terminal GAP cycle also accepts, so the idle gap is exactly 1 + gap_cycles_i.
        arb_open = (state_q == IDLE)   || (state_q == GAP && gap_q == '0 && !lock_q);
        own_open = (state_q == LOCKED) || (state_q == GAP && gap_q == '0 && lock_q);
        ready    = '0;
        if (arb_open) begin
            ready = arb_gnt;
        end else if (own_open) begin
            ready = req_bus.req_valid & grant_q;
        end
        if (!rst_ni) begin
            ready = '0;
        end

        sel_data = '0;
        sel_last = 1'b0;
        sel_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ready[k]) begin
                sel_data = req_bus.req_data[k*DATA_W +: DATA_W];
                sel_last = req_bus.req_last[k];
                sel_idx  = PtrW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        gap_d   = gap_q;
        data_d  = data_q;
        last_d  = last_q;
        tx_en_d = tx_en_q;
        grant_d = grant_q;

        case (state_q)
            TX: begin
                if (tx_done_i) begin
                    tx_en_d = 1'b0;
                    gap_d   = gap_cycles_i;
                    state_d = GAP;
                    if (last_q) begin
                        ptr_d  = owner_q;
                        lock_d = 1'b0;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (lock_q) begin
                    state_d = LOCKED;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: ;
        endcase

        if (|ready) begin
            data_d  = sel_data;
            last_d  = sel_last;
            owner_d = sel_idx;
            grant_d = ready;
            tx_en_d = 1'b1;
            state_d = TX;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= PtrW'(NUM_REQ - 1);
            owner_q <= '0;
            lock_q  <= 1'b0;
            gap_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            tx_en_q <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            last_q  <= last_d;
            tx_en_q <= tx_en_d;
            grant_q <= grant_d;
        end
    end

    assign req_bus.req_ready = ready;
    assign tx_en_o           = tx_en_q;
    assign tx_data_o         = data_q;
    assign grant_o           = grant_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, fairness, packet lock, gap, reset, spurious done.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned GW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [GW-1:0] gap_cycles;
    logic          tx_en;
    logic [DW-1:0] tx_data;
    logic          tx_done;
    logic [NR-1:0] grant;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) rbus ();

    uart_tx_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .GAP_W   (GW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_bus      (rbus),
        .gap_cycles_i (gap_cycles),
        .tx_en_o      (tx_en),
        .tx_data_o    (tx_data),
        .tx_done_i    (tx_done),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input logic l);
        rbus.req_data[k*DW +: DW] = d;
        rbus.req_last[k]          = l;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        settle();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        rbus.req_valid = '0;
        rbus.req_data  = '0;
        rbus.req_last  = '0;
        tx_done        = 1'b0;
        gap_cycles     = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic wait_tx_en(input string tag);
        int n = 0;
        while (tx_en !== 1'b1 && n < 20) begin
            cyc();
            settle();
            n++;
        end
        check_eq(tag, tx_en, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_g;
        int         exp_k;
        int         lows;

        do_reset();
        check_eq("rst_ready", rbus.req_ready, 0);
        check_eq("rst_tx_en", tx_en, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);

        // Single byte
        set_req(0, 8'h55, 1'b1);
        rbus.req_valid = 4'b0001;
        settle();
        check_eq("t1_ready", rbus.req_ready, 4'b0001);
        cyc();
        rbus.req_valid = '0;
        set_req(0, 8'hEE, 1'b0);
        settle();
        check_eq("t1_tx_en", tx_en, 1);
        check_eq("t1_data", tx_data, 8'h55);
        check_eq("t1_grant", grant, 4'b0001);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_ready_tx", rbus.req_ready, 0);
        cyc();
        cyc();
        settle();
        check_eq("t1_hold_data", tx_data, 8'h55);
        pulse_done();
        check_eq("t1_en_low", tx_en, 0);
        check_eq("t1_gap_grant", grant, 4'b0001);
        cyc();
        settle();
        check_eq("t1_idle_grant", grant, 0);
        check_eq("t1_idle_busy", busy, 0);

        // Fairness
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 8'h10 + 8'(k), 1'b1);
        rbus.req_valid = 4'b1111;
        for (int f = 0; f < 6; f++) begin
            exp_k = f % 4;
            exp_g = 4'(1 << exp_k);
            wait_tx_en("fair_en");
            check_eq("fair_grant", grant, exp_g);
            check_eq("fair_data", tx_data, 8'h10 + 8'(exp_k));
            cyc();
            pulse_done();
        end

        // Packet lock
        do_reset();
        set_req(2, 8'hA1, 1'b0);
        rbus.req_valid = 4'b0100;
        settle();
        check_eq("lock_ready1", rbus.req_ready, 4'b0100);
        cyc();
        set_req(2, 8'hA2, 1'b1);
        set_req(0, 8'h0F, 1'b1);
        rbus.req_valid = 4'b0101;
        settle();
        check_eq("lock_data1", tx_data, 8'hA1);
        check_eq("lock_ready_tx", rbus.req_ready, 0);
        pulse_done();
        check_eq("lock_ready_owner", rbus.req_ready, 4'b0100);
        cyc();
        settle();
        check_eq("lock_en2", tx_en, 1);
        check_eq("lock_data2", tx_data, 8'hA2);
        check_eq("lock_grant2", grant, 4'b0100);
        rbus.req_valid = 4'b0001;
        pulse_done();
        check_eq("lock_ready_r0", rbus.req_ready, 4'b0001);
        cyc();
        settle();
        check_eq("lock_data3", tx_data, 8'h0F);
        check_eq("lock_grant3", grant, 4'b0001);

        // Inter-frame gap
        do_reset();
        set_req(0, 8'h31, 1'b1);
        set_req(1, 8'h32, 1'b1);
        rbus.req_valid = 4'b0011;
        settle();
        check_eq("gap_ready", rbus.req_ready, 4'b0001);
        cyc();
        rbus.req_valid = 4'b0010;
        settle();
        check_eq("gap_data1", tx_data, 8'h31);
        gap_cycles = 16'd5;
        pulse_done();
        lows = 0;
        while (tx_en === 1'b0 && lows < 20) begin
            lows++;
            if (lows == 3) gap_cycles = '0;
            cyc();
            settle();
        end
        check_eq("gap_low_cycles", lows, 6);
        check_eq("gap_data2", tx_data, 8'h32);
        check_eq("gap_grant2", grant, 4'b0010);

        // Asynchronous reset mid-frame
        #1;
        rst_n = 1'b0;
        rbus.req_valid = 4'b1111;
        set_req(0, 8'h44, 1'b1);
        #1;
        check_eq("arst_tx_en", tx_en, 0);
        check_eq("arst_grant", grant, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_ready", rbus.req_ready, 0);
        #1;
        rst_n = 1'b1;
        settle();
        check_eq("arst_first_ready", rbus.req_ready, 4'b0001);
        cyc();
        rbus.req_valid = '0;
        settle();
        check_eq("arst_first_grant", grant, 4'b0001);
        check_eq("arst_first_data", tx_data, 8'h44);

        // Spurious done in GAP and IDLE
        gap_cycles = 16'd3;
        pulse_done();
        check_eq("sp_gap_en", tx_en, 0);
        pulse_done();
        check_eq("sp_gap_busy", busy, 1);
        check_eq("sp_gap_tx_en", tx_en, 0);
        check_eq("sp_gap_ready", rbus.req_ready, 0);
        cyc();
        cyc();
        settle();
        check_eq("sp_gap_still", busy, 1);
        cyc();
        settle();
        check_eq("sp_gap_end_busy", busy, 0);
        check_eq("sp_gap_end_grant", grant, 0);
        pulse_done();
        check_eq("sp_idle_busy", busy, 0);
        check_eq("sp_idle_tx_en", tx_en, 0);
        check_eq("sp_idle_ready", rbus.req_ready, 0);
        check_eq("sp_idle_grant", grant, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
